// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one memory port between fetch and data requesters,
// data first with a starvation guard that eventually lets a pending fetch win.
module memory_port_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_ack,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  grant_dm
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [3:0] WAIT_INIT = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  state_t state;
  logic [3:0] wait_cnt, starve_cnt;
  logic txn_we, fetch_wins;
  assign fetch_wins = if_req && (!dm_req || starve_cnt == LIMIT);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      txn_we     <= 1'b0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      grant_dm   <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          // a data win only counts against fetch while fetch is actually waiting
          starve_cnt <= (!if_req || fetch_wins) ? '0 : starve_cnt + 4'(starve_cnt != LIMIT);
          if (if_req || dm_req) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            mem_en    <= 1'b1;
            grant_dm  <= !fetch_wins;
            mem_we    <= !fetch_wins && dm_we;
            txn_we    <= !fetch_wins && dm_we;
            mem_addr  <= fetch_wins ? if_addr : dm_addr;
            mem_wdata <= fetch_wins ? mem_wdata : dm_wdata;
          end
        end
        ISSUE: begin
          mem_en   <= 1'b0;
          mem_we   <= 1'b0;
          wait_cnt <= WAIT_INIT;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state  <= RESP;
            if_ack <= !grant_dm;
            dm_ack <= grant_dm;
            if (!grant_dm) if_rdata <= mem_rdata;
            else if (!txn_we) dm_rdata <= mem_rdata;
          end else wait_cnt <= wait_cnt - 4'd1;
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter: directed stimulus with issue/ack scoreboards for the
// default arbiter, plus latency probes on MEM_LATENCY = 1 and 5 instances.
module tb_memory_port_arbiter;
  logic clock = 1'b0, reset_n = 1'b0;
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  int errors = 0, checks = 0;

  logic        if_req = 0, dm_req = 0, dm_we = 0;
  logic [15:0] if_addr = 0, dm_addr = 0, dm_wdata = 0;
  logic        if_ack, dm_ack, mem_en, mem_we, busy, grant_dm;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

  memory_port_arbiter u_dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_dm(grant_dm)
  );

  // memory model: read data is valid only in the cycle exactly MEM_LATENCY after mem_en
  logic [15:0] mem [0:65535];
  logic [3:0]  rcnt = 0;
  logic [15:0] raddr = 0;
  always @(posedge clock) begin
    if (mem_en) begin
      rcnt  <= 4'd1;
      raddr <= mem_addr;
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end else if (rcnt != 0 && rcnt != 15) rcnt <= rcnt + 4'd1;
  end
  assign mem_rdata = (rcnt == 4'd2) ? mem[raddr] : 16'hDEAD;

  logic        l1_req = 0, l5_req = 0;
  logic        l1_ack, l5_ack, l1_dm_ack, l5_dm_ack, l1_en, l5_en, l1_we, l5_we;
  logic        l1_busy, l5_busy, l1_gnt, l5_gnt;
  logic [15:0] l1_rdata, l5_rdata, l1_dm_rdata, l5_dm_rdata, l1_addr, l5_addr;
  logic [15:0] l1_wdata, l5_wdata, l1_mrdata, l5_mrdata;
  logic [3:0]  r1 = 0, r5 = 0;

  memory_port_arbiter #(.MEM_LATENCY(1)) u_l1 (
    .clock(clock), .reset_n(reset_n),
    .if_req(l1_req), .if_addr(16'h0040), .if_ack(l1_ack), .if_rdata(l1_rdata),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(16'h0000), .dm_wdata(16'h0000),
    .dm_ack(l1_dm_ack), .dm_rdata(l1_dm_rdata),
    .mem_en(l1_en), .mem_we(l1_we), .mem_addr(l1_addr), .mem_wdata(l1_wdata),
    .mem_rdata(l1_mrdata), .busy(l1_busy), .grant_dm(l1_gnt)
  );
  memory_port_arbiter #(.MEM_LATENCY(5)) u_l5 (
    .clock(clock), .reset_n(reset_n),
    .if_req(l5_req), .if_addr(16'h0050), .if_ack(l5_ack), .if_rdata(l5_rdata),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(16'h0000), .dm_wdata(16'h0000),
    .dm_ack(l5_dm_ack), .dm_rdata(l5_dm_rdata),
    .mem_en(l5_en), .mem_we(l5_we), .mem_addr(l5_addr), .mem_wdata(l5_wdata),
    .mem_rdata(l5_mrdata), .busy(l5_busy), .grant_dm(l5_gnt)
  );
  always @(posedge clock) begin
    r1 <= l1_en ? 4'd1 : (r1 != 0 && r1 != 15) ? r1 + 4'd1 : r1;
    r5 <= l5_en ? 4'd1 : (r5 != 0 && r5 != 15) ? r5 + 4'd1 : r5;
  end
  assign l1_mrdata = (r1 == 4'd1) ? 16'h0A01 : 16'hDEAD;
  assign l5_mrdata = (r5 == 4'd5) ? 16'h0A05 : 16'hDEAD;

  typedef struct {logic [15:0] addr; logic we; logic [15:0] wdata; int cyc;} iss_t;
  typedef struct {logic dm; logic [15:0] rdata; int cyc;} ack_t;
  iss_t iq[$];
  ack_t aq[$];
  iss_t ie;
  ack_t ae;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic dm, input logic we, input logic [15:0] addr,
                      input logic [15:0] wdata, input logic [15:0] rdata, input int c0);
    iq.push_back('{addr, we, wdata, c0});
    aq.push_back('{dm, rdata, c0 + 3});
  endtask

  task automatic wait_ack(input logic dm_side);
    int n = 0;
    while (!(dm_side ? dm_ack : if_ack) && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("ack_timeout", 32'(n < 40), 1);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) if (reset_n) begin
    if (mem_en) begin
      if (iq.size() == 0) chk("issue_unexpected", 1, 0);
      else begin
        ie = iq.pop_front();
        chk("issue_cycle", cyc, ie.cyc);
        chk("issue_addr", mem_addr, ie.addr);
        chk("issue_we", mem_we, ie.we);
        if (ie.we) chk("issue_wdata", mem_wdata, ie.wdata);
      end
    end
    if (if_ack || dm_ack) begin
      if (aq.size() == 0) chk("ack_unexpected", {if_ack, dm_ack}, 0);
      else begin
        ae = aq.pop_front();
        chk("ack_port", {if_ack, dm_ack}, ae.dm ? 2'b01 : 2'b10);
        chk("ack_grant", grant_dm, ae.dm);
        chk("ack_cycle", cyc, ae.cyc);
        chk("ack_rdata", ae.dm ? dm_rdata : if_rdata, ae.rdata);
      end
    end
  end

  int c0, t1, t5;
  initial begin
    mem[16'h0010] <= 16'hBEEF;
    mem[16'h0020] <= 16'hCAFE;
    mem[16'h0200] <= 16'h0000;
    mem[16'h0300] <= 16'h5A5A;
    mem[16'h0400] <= 16'h1111;
    repeat (3) @(negedge clock);
    chk("rst_ctrl", {if_ack, dm_ack, mem_en, mem_we, busy, grant_dm}, 0);
    chk("rst_addr_wdata", {mem_addr, mem_wdata}, 0);
    chk("rst_rdata", {if_rdata, dm_rdata}, 0);
    reset_n = 1;

    @(negedge clock);
    if_addr = 16'h0010; if_req = 1; c0 = cyc + 1;
    push(0, 0, 16'h0010, 0, 16'hBEEF, c0);
    wait_ack(0);
    if_req = 0;
    chk("busy_after_ack", busy, 0);

    @(negedge clock);
    dm_addr = 16'h0200; dm_wdata = 16'h1234; dm_we = 1; dm_req = 1; c0 = cyc + 1;
    push(1, 1, 16'h0200, 16'h1234, 16'h0000, c0);
    wait_ack(1);
    dm_req = 0; dm_we = 0;
    chk("mem_written", mem[16'h0200], 16'h1234);

    @(negedge clock);
    dm_req = 1; c0 = cyc + 1;
    push(1, 0, 16'h0200, 0, 16'h1234, c0);
    wait_ack(1);
    dm_req = 0;

    @(negedge clock);
    dm_addr = 16'h0300; dm_req = 1; if_addr = 16'h0020; if_req = 1; c0 = cyc + 1;
    push(1, 0, 16'h0300, 0, 16'h5A5A, c0);
    push(0, 0, 16'h0020, 0, 16'hCAFE, c0 + 5);
    wait_ack(1);
    dm_req = 0;
    wait_ack(0);
    if_req = 0;

    @(negedge clock);
    dm_addr = 16'h0400; dm_req = 1; if_addr = 16'h0010; if_req = 1; c0 = cyc + 1;
    for (int k = 0; k < 4; k++) push(1, 0, 16'h0400, 0, 16'h1111, c0 + 5 * k);
    push(0, 0, 16'h0010, 0, 16'hBEEF, c0 + 20);
    repeat (4) wait_ack(1);
    wait_ack(0);
    dm_req = 0; if_req = 0;
    chk("starve_cnt_cleared", u_dut.starve_cnt, 0);

    @(negedge clock);
    l1_req = 1; l5_req = 1; c0 = cyc + 1; t1 = -1; t5 = -1;
    for (int n = 0; n < 20 && (t1 < 0 || t5 < 0); n++) begin
      @(negedge clock);
      if (l1_ack && t1 < 0) begin t1 = cyc; l1_req = 0; end
      if (l5_ack && t5 < 0) begin t5 = cyc; l5_req = 0; end
    end
    l1_req = 0; l5_req = 0;
    chk("lat1_cycles", t1 - c0 + 1, 3);
    chk("lat5_cycles", t5 - c0 + 1, 7);
    chk("lat1_rdata", l1_rdata, 16'h0A01);
    chk("lat5_rdata", l5_rdata, 16'h0A05);

    @(negedge clock);
    if_addr = 16'h0010; if_req = 1; c0 = cyc + 1;
    iq.push_back('{16'h0010, 1'b0, 16'h0000, c0});
    repeat (2) @(negedge clock);
    #2 reset_n = 0;
    #1;
    chk("midrst_ctrl", {if_ack, dm_ack, mem_en, mem_we, busy, grant_dm}, 0);
    chk("midrst_addr_wdata", {mem_addr, mem_wdata}, 0);
    chk("midrst_rdata", {if_rdata, dm_rdata}, 0);
    if_req = 0;
    repeat (3) @(negedge clock);
    reset_n = 1;
    repeat (8) @(negedge clock);

    if_addr = 16'h0020; if_req = 1; c0 = cyc + 1;
    push(0, 0, 16'h0020, 0, 16'hCAFE, c0);
    wait_ack(0);
    if_req = 0;

    repeat (3) @(negedge clock);
    chk("queues_drained", iq.size() + aq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
